// File: rtl/dct_block_ctrl.sv
// Row sequencer for an 8-sample DCT unit: accept, accumulate, wait LAT cycles, hold result.
// Optional stall statistic on stall_cnt when DCT_CTRL_STAT_EN is defined.
module dct_block_ctrl #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        acc_clr,
  output logic        acc_en,
  output logic [2:0]  coef_sel,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [2:0]  result_row,
  output logic        block_done
`ifdef DCT_CTRL_STAT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  lat_q, lat_d;
  logic [2:0]  row_q, row_d;
  logic        rv_q, rv_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      lat_q   <= 4'd0;
      row_q   <= 3'd0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      row_q   <= row_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    row_d     = row_q;
    rv_d      = rv_q;
    done_d    = done_q;
    din_ready = ena && ((state_q == S_IDLE) || (state_q == S_ACC));
    acc_en    = din_valid && din_ready;
    acc_clr   = acc_en && (cnt_q == 3'd0);
    coef_sel  = cnt_q;

    // Everything, including the done pulse register, freezes while ena is low.
    if (ena) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc_en) begin
            cnt_d   = cnt_q + 3'd1;
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          if (acc_en) begin
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              lat_d   = LAT_LOAD;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_WAIT: begin
          if (lat_q == 4'd0) begin
            state_d = S_HOLD;
            rv_d    = 1'b1;
          end else begin
            lat_d = lat_q - 4'd1;
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            rv_d    = 1'b0;
            row_d   = row_q + 3'd1;
            done_d  = (row_q == 3'd7);
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign result_valid = rv_q;
  assign result_row   = row_q;
  // Gated so a pulse never shows during a freeze; it appears on the next enabled cycle.
  assign block_done   = done_q && ena;

`ifdef DCT_CTRL_STAT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ena && din_valid && !din_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Directed bench for dct_block_ctrl: row sequencing, latency, stalls, reset abandon, freeze.
module tb_dct_block_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        din_valid;
  logic        din_ready;
  logic        acc_clr;
  logic        acc_en;
  logic [2:0]  coef_sel;
  logic        result_valid;
  logic        result_ready;
  logic [2:0]  result_row;
  logic        block_done;
`ifdef DCT_CTRL_STAT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dct_block_ctrl #(.LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .coef_sel     (coef_sel),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_row   (result_row),
    .block_done   (block_done)
`ifdef DCT_CTRL_STAT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer num samples back-to-back; expected coefficient index starts at start.
  task automatic feed(input int start, input int num);
    for (int i = 0; i < num; i++) begin
      din_valid = 1'b1;
      #1;
      check("din_ready", din_ready, 1);
      check("acc_en", acc_en, 1);
      check("coef_sel", coef_sel, start + i);
      check("acc_clr", acc_clr, ((start + i) == 0) ? 1 : 0);
      cyc();
    end
    din_valid = 1'b0;
  endtask

  // Called right after the edge that took the 8th sample; counts edges until result_valid.
  task automatic wait_result(input int exp_row, input int exp_lat);
    int n;
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check("latency", n, exp_lat);
    check("result_row", result_row, exp_row);
  endtask

  task automatic consume(input int exp_row, input bit exp_done);
    result_ready = 1'b1;
    #1;
    check("rv_before_consume", result_valid, 1);
    check("row_before_consume", result_row, exp_row);
    cyc();
    result_ready = 1'b0;
    #1;
    check("rv_cleared", result_valid, 0);
    check("block_done", block_done, exp_done);
    check("din_ready_idle", din_ready, 1);
    $display("row %0d consumed block_done=%0b", exp_row, block_done);
    cyc();
    check("block_done_pulse_end", block_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
`ifdef DCT_CTRL_STAT_EN
    logic [15:0] stall_base;
`endif
    rst = 1'b1;
    ena = 1'b1;
    din_valid = 1'b0;
    result_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_rv", result_valid, 0);
    check("rst_done", block_done, 0);
    check("rst_row", result_row, 0);
    check("rst_coef", coef_sel, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_acc_en", acc_en, 0);
`ifdef DCT_CTRL_STAT_EN
    check("rst_stall", stall_cnt, 0);
`endif

    // First row: clr on sample 0 only, coef 0..7, result after LAT, row 0
    feed(0, 8);
    #1;
    check("wait_din_ready", din_ready, 0);
    check("wait_rv", result_valid, 0);
    wait_result(0, LAT);
    consume(0, 1'b0);

    // Remaining rows of the block; done only after row 7
    for (int r = 1; r < 8; r++) begin
      feed(0, 8);
      wait_result(r, LAT);
      consume(r, (r == 7) ? 1'b1 : 1'b0);
    end
    check("row_wrapped", result_row, 0);

    // Gap of 3 cycles after sample 4; stray result_ready outside HOLD ignored
    feed(0, 4);
    result_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("gap_din_ready", din_ready, 1);
      check("gap_coef_held", coef_sel, 4);
      check("gap_acc_en", acc_en, 0);
      cyc();
    end
    result_ready = 1'b0;
    check("gap_rv", result_valid, 0);
    check("gap_row", result_row, 0);
    feed(4, 4);
    wait_result(0, LAT);
    consume(0, 1'b0);

    // Downstream backpressure: 10 HOLD cycles with din_valid high
    feed(0, 8);
    din_valid = 1'b1;
`ifdef DCT_CTRL_STAT_EN
    stall_base = stall_cnt;
`endif
    wait_result(1, LAT);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("hold_din_ready", din_ready, 0);
      check("hold_rv", result_valid, 1);
      cyc();
    end
`ifdef DCT_CTRL_STAT_EN
    check("stall_delta", stall_cnt - stall_base, LAT + 10);
`endif
    din_valid = 1'b0;
    consume(1, 1'b0);

    // Reset after sample 5 abandons the row
    feed(0, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("abandon_coef", coef_sel, 0);
    check("abandon_row", result_row, 0);
    bad = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      if (result_valid !== 1'b0) bad = 1;
      cyc();
    end
    check("abandon_no_rv", bad, 0);
    feed(0, 8);
    wait_result(0, LAT);
    consume(0, 1'b0);

    // ena low in IDLE: no handshake
    ena = 1'b0;
    din_valid = 1'b1;
    #1;
    check("frz_idle_ready", din_ready, 0);
    check("frz_idle_acc_en", acc_en, 0);
    cyc();
    check("frz_idle_coef", coef_sel, 0);
    ena = 1'b1;
    din_valid = 1'b0;

    // ena low for 4 cycles during WAIT delays the result by 4
    feed(0, 8);
    ena = 1'b0;
    din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("frz_rv", result_valid, 0);
      check("frz_ready", din_ready, 0);
      check("frz_acc_en", acc_en, 0);
      check("frz_done", block_done, 0);
      check("frz_row", result_row, 1);
      cyc();
    end
    ena = 1'b1;
    din_valid = 1'b0;
    wait_result(1, LAT);
    consume(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
